// File: rtl/fpdiv_seq.sv
// Control sequencer for the Goldschmidt fpdiv datapath. It drives the multiplier operand
// selects and the register load enables, and latches the rounding mode for one operation.
module fpdiv_seq #(
    parameter int ITERS = 5,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             rm_in,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [1:0]       sel_mux4,
    output logic [1:0]       sel_mux3,
    output logic             en_a,
    output logic             en_b,
    output logic             en_rem,
    output logic             rm,
    output logic [CNT_W-1:0] iter
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        IA_NUM = 3'd1,
        IA_DEN = 3'd2,
        IT_NUM = 3'd3,
        IT_DEN = 3'd4,
        REM    = 3'd5,
        DONE   = 3'd6
    } state_t;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic [1:0] sel_mux4;
        logic [1:0] sel_mux3;
        logic       en_a;
        logic       en_b;
        logic       en_rem;
    } ctl_t;

    localparam logic [CNT_W-1:0] ITERS_C = CNT_W'(ITERS);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
    localparam logic [CNT_W-1:0] ZERO_C  = '0;
    localparam ctl_t             CTL_IDLE = '0;

    state_t           state_r;
    state_t           next_state_s;
    logic [CNT_W-1:0] iter_r;
    logic [CNT_W-1:0] next_iter_s;
    logic             rm_r;
    logic             next_rm_s;
    ctl_t             ctl_r;

    // Output word for a given state; the flops load the word for the state being entered.
    function automatic ctl_t decode(input state_t s);
        ctl_t c;
        c = CTL_IDLE;
        case (s)
            IDLE:    c = CTL_IDLE;
            IA_NUM:  begin c.busy = 1'b1; c.sel_mux4 = 2'b00; c.sel_mux3 = 2'b00; c.en_a = 1'b1; end
            IA_DEN:  begin c.busy = 1'b1; c.sel_mux4 = 2'b01; c.sel_mux3 = 2'b00; c.en_b = 1'b1; end
            IT_NUM:  begin c.busy = 1'b1; c.sel_mux4 = 2'b10; c.sel_mux3 = 2'b01; c.en_a = 1'b1; end
            IT_DEN:  begin c.busy = 1'b1; c.sel_mux4 = 2'b11; c.sel_mux3 = 2'b01; c.en_b = 1'b1; end
            REM:     begin c.busy = 1'b1; c.sel_mux4 = 2'b10; c.sel_mux3 = 2'b10; c.en_rem = 1'b1; end
            DONE:    begin c.busy = 1'b1; c.done = 1'b1; c.sel_mux4 = 2'b10; c.sel_mux3 = 2'b10; end
            default: c = CTL_IDLE;
        endcase
        return c;
    endfunction

    // Next-state, iteration and rounding-mode logic; abort wins over everything, including start.
    always_comb begin
        next_state_s = state_r;
        next_iter_s  = iter_r;
        next_rm_s    = rm_r;
        if (abort) begin
            next_state_s = IDLE;
            next_iter_s  = ZERO_C;
        end else begin
            case (state_r)
                IDLE: begin
                    next_iter_s = ZERO_C;
                    if (start) begin
                        next_state_s = IA_NUM;
                        next_rm_s    = rm_in;
                    end else begin
                        next_state_s = IDLE;
                    end
                end
                IA_NUM: next_state_s = IA_DEN;
                IA_DEN: begin
                    next_state_s = IT_NUM;
                    next_iter_s  = ONE_C;
                end
                IT_NUM: next_state_s = IT_DEN;
                IT_DEN: begin
                    if (iter_r < ITERS_C) begin
                        next_state_s = IT_NUM;
                        next_iter_s  = iter_r + ONE_C;
                    end else begin
                        next_state_s = REM;
                        next_iter_s  = ZERO_C;
                    end
                end
                REM:  next_state_s = DONE;
                DONE: next_state_s = IDLE;
                default: begin
                    next_state_s = IDLE;
                    next_iter_s  = ZERO_C;
                end
            endcase
        end
    end

    // State, counter, rounding mode and decoded outputs, all registered together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
            iter_r  <= ZERO_C;
            rm_r    <= 1'b0;
            ctl_r   <= CTL_IDLE;
        end else begin
            state_r <= next_state_s;
            iter_r  <= next_iter_s;
            rm_r    <= next_rm_s;
            ctl_r   <= decode(next_state_s);
        end
    end

    assign busy     = ctl_r.busy;
    assign done     = ctl_r.done;
    assign sel_mux4 = ctl_r.sel_mux4;
    assign sel_mux3 = ctl_r.sel_mux3;
    assign en_a     = ctl_r.en_a;
    assign en_b     = ctl_r.en_b;
    assign en_rem   = ctl_r.en_rem;
    assign rm       = rm_r;
    assign iter     = iter_r;

endmodule

// File: tb/tb_fpdiv_seq.sv
// Directed bench for fpdiv_seq: main instance at ITERS=5, plus ITERS=1 and ITERS=15 instances
// sharing the same stimulus for the latency corners.
module tb_fpdiv_seq;

    logic clk = 1'b0;
    logic reset, start, rm_in, abort;

    logic       busy, done, en_a, en_b, en_rem, rm;
    logic [1:0] sel_mux4, sel_mux3;
    logic [3:0] iter;

    logic       busy1, done1, ea1, eb1, er1, rm1;
    logic [1:0] s4_1, s3_1;
    logic [3:0] iter1;

    logic       busy15, done15, ea15, eb15, er15, rm15;
    logic [1:0] s4_15, s3_15;
    logic [3:0] iter15;

    logic [13:0] obs;
    logic [13:0] obs1;
    assign obs  = {busy, done, sel_mux4, sel_mux3, en_a, en_b, en_rem, rm, iter};
    assign obs1 = {busy1, done1, s4_1, s3_1, ea1, eb1, er1, rm1, iter1};

    int n_vec = 0;
    int n_err = 0;

    fpdiv_seq #(.ITERS(5), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .start(start), .rm_in(rm_in), .abort(abort),
        .busy(busy), .done(done), .sel_mux4(sel_mux4), .sel_mux3(sel_mux3),
        .en_a(en_a), .en_b(en_b), .en_rem(en_rem), .rm(rm), .iter(iter));

    fpdiv_seq #(.ITERS(1), .CNT_W(4)) dut1 (
        .clk(clk), .reset(reset), .start(start), .rm_in(rm_in), .abort(abort),
        .busy(busy1), .done(done1), .sel_mux4(s4_1), .sel_mux3(s3_1),
        .en_a(ea1), .en_b(eb1), .en_rem(er1), .rm(rm1), .iter(iter1));

    fpdiv_seq #(.ITERS(15), .CNT_W(4)) dut15 (
        .clk(clk), .reset(reset), .start(start), .rm_in(rm_in), .abort(abort),
        .busy(busy15), .done(done15), .sel_mux4(s4_15), .sel_mux3(s3_15),
        .en_a(ea15), .en_b(eb15), .en_rem(er15), .rm(rm15), .iter(iter15));

    // Free-running clock, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    function automatic logic [13:0] mk(input logic b, input logic d, input logic [1:0] s4,
                                       input logic [1:0] s3, input logic a, input logic eb,
                                       input logic er, input logic r, input logic [3:0] it);
        return {b, d, s4, s3, a, eb, er, r, it};
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic flush;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick();
    endtask

    initial begin
        logic [13:0] x;
        int d1_at, d15_at, d1_cnt, d15_cnt, d5_cnt, rem_cnt, a_cnt, b_cnt;
        int first_done, second_done, bad, n;

        reset = 1'b0; start = 1'b0; rm_in = 1'b0; abort = 1'b0;
        #3;
        check_val("rst_main", obs, 14'd0);
        check_val("rst_it1", obs1, 14'd0);
        check_val("rst_it15", {busy15, done15, s4_15, s3_15, ea15, eb15, er15, rm15, iter15}, 14'd0);
        tick(); tick();
        reset = 1'b1;
        tick();

        // Nominal run, rm_in=1; edge 1 is the edge that accepts start.
        d1_at = 0; d15_at = 0; d1_cnt = 0; d15_cnt = 0; d5_cnt = 0; rem_cnt = 0;
        rm_in = 1'b1; start = 1'b1;
        for (int e = 1; e <= 36; e++) begin
            tick();
            if (e == 1) begin start = 1'b0; rm_in = 1'b0; end
            if (e == 1)       x = mk(1'b1, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0);
            else if (e == 2)  x = mk(1'b1, 1'b0, 2'd1, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0);
            else if (e <= 12) x = (e % 2 == 1) ?
                                  mk(1'b1, 1'b0, 2'd2, 2'd1, 1'b1, 1'b0, 1'b0, 1'b1, 4'((e - 1) / 2)) :
                                  mk(1'b1, 1'b0, 2'd3, 2'd1, 1'b0, 1'b1, 1'b0, 1'b1, 4'((e - 2) / 2));
            else if (e == 13) x = mk(1'b1, 1'b0, 2'd2, 2'd2, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0);
            else if (e == 14) x = mk(1'b1, 1'b1, 2'd2, 2'd2, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
            else              x = mk(1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
            if (e <= 16) check_val($sformatf("nom_e%0d", e), obs, x);
            if (done)   d5_cnt++;
            if (en_rem) rem_cnt++;
            if (done1)  begin d1_cnt++;  if (d1_at == 0)  d1_at = e;  end
            if (done15) begin d15_cnt++; if (d15_at == 0) d15_at = e; end
            if (e == 4) check_val("it1_seq_e4", obs1, mk(1'b1, 1'b0, 2'd3, 2'd1, 1'b0, 1'b1, 1'b0, 1'b1, 4'd1));
            if (e == 5) check_val("it1_seq_e5", obs1, mk(1'b1, 1'b0, 2'd2, 2'd2, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0));
        end
        check_val("nom_done_cnt", d5_cnt, 1);
        check_val("nom_rem_cnt", rem_cnt, 1);
        check_val("it1_done_edge", d1_at, 6);
        check_val("it1_done_cnt", d1_cnt, 1);
        check_val("it15_done_edge", d15_at, 34);
        check_val("it15_done_cnt", d15_cnt, 1);

        // Start held high: next op starts right after DONE->IDLE, dones 15 apart.
        first_done = 0; second_done = 0; a_cnt = 0; b_cnt = 0;
        start = 1'b1; rm_in = 1'b1;
        for (int e = 1; e <= 32; e++) begin
            tick();
            if (done) begin
                if (first_done == 0) first_done = e;
                else if (second_done == 0) second_done = e;
            end
            if (en_a && en_b || en_a && en_rem || en_b && en_rem) a_cnt++;
            if (e == 15) check_val("held_idle_e15", busy, 1'b0);
            if (e == 16) check_val("held_ianum_e16", obs, mk(1'b1, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0));
        end
        start = 1'b0;
        check_val("held_done1", first_done, 14);
        check_val("held_done2", second_done, 29);
        check_val("en_exclusive", a_cnt, 0);
        flush();
        check_val("flush_idle", busy, 1'b0);

        // rm captured at start only, held while rm_in toggles.
        bad = 0;
        rm_in = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        if (rm !== 1'b0) bad++;
        for (int e = 2; e <= 16; e++) begin
            rm_in = ~rm_in;
            tick();
            if (rm !== 1'b0) bad++;
        end
        check_val("rm_hold", bad, 0);
        rm_in = 1'b1; start = 1'b1;
        tick();
        start = 1'b0; rm_in = 1'b0;
        check_val("rm_new", rm, 1'b1);
        flush();

        // Abort at IT_DEN iter=3 (edge 8).
        rm_in = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int e = 2; e <= 8; e++) tick();
        check_val("itden3", obs, mk(1'b1, 1'b0, 2'd3, 2'd1, 1'b0, 1'b1, 1'b0, 1'b1, 4'd3));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_val("abort_idle", obs, mk(1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0));
        d5_cnt = 0;
        for (int e = 0; e < 20; e++) begin
            tick();
            if (done) d5_cnt++;
        end
        check_val("abort_no_done", d5_cnt, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 1;
        while (!done && n < 60) begin
            tick();
            n++;
        end
        check_val("restart_lat", n, 14);
        tick();

        // Abort beats start in IDLE.
        start = 1'b1; abort = 1'b1;
        tick();
        check_val("abort_pri", busy, 1'b0);
        start = 1'b0; abort = 1'b0;
        tick();

        // Async reset between edges during IT_NUM.
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        check_val("pre_rst_itnum", obs, mk(1'b1, 1'b0, 2'd2, 2'd1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd1));
        #2;
        reset = 1'b0;
        #1;
        check_val("async_rst", obs, 14'd0);
        #2;
        reset = 1'b1;
        bad = 0;
        for (int e = 0; e < 5; e++) begin
            tick();
            if (obs !== 14'd0) bad++;
        end
        check_val("post_rst_quiet", bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
